gpu_dispatcher: RTL and testbench

GPU_DISPATCHER -- requirements
Module: gpu_dispatcher

---
 rtl/gpu_pkg.sv | 56 +++++
 rtl/dispatch_timer.sv | 42 ++++
 rtl/gpu_dispatcher.sv | 203 ++++++++++++++++++++
 tb/tb_gpu_dispatcher.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared types for the GPU command dispatcher: FSM states, opcode and
// error-code constants, and the opcode-to-engine decoder.
package gpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_POP   = 2'd3
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LINE = 4'b0100;
  localparam logic [3:0] OP_FILL = 4'b0101;
  localparam logic [3:0] OP_ENG3 = 4'b0110;
  localparam logic [3:0] OP_ARC  = 4'b0111;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    CMD_NOP = 2'd0,
    CMD_ENG = 2'd1,
    CMD_ILL = 2'd2
  } cmd_kind_t;

  typedef struct packed {
    cmd_kind_t  kind;
    logic [1:0] eng;
  } cmd_dec_t;

  // Engine 3 exists only when the instance has more than three engines.
  function automatic cmd_dec_t decode_op(input logic [3:0] op, input int num_eng);
    cmd_dec_t d;
    d.kind = CMD_ILL;
    d.eng  = 2'd0;
    case (op)
      OP_NOP:  d.kind = CMD_NOP;
      OP_LINE: begin d.kind = CMD_ENG; d.eng = 2'd0; end
      OP_FILL: begin d.kind = CMD_ENG; d.eng = 2'd1; end
      OP_ARC:  begin d.kind = CMD_ENG; d.eng = 2'd2; end
      OP_ENG3: begin
        if (num_eng > 32'sd3) begin
          d.kind = CMD_ENG;
          d.eng  = 2'd3;
        end else begin
          d.kind = CMD_ILL;
        end
      end
      default: d.kind = CMD_ILL;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/dispatch_timer.sv
// Watchdog for an in-flight command: counts enabled cycles from a clear and
// flags when the count reaches TIMEOUT_CYC-1.
module dispatch_timer #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int            CW    = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Clear wins over count; the counter parks at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == LIMIT);

endmodule

// File: rtl/gpu_dispatcher.sv
// Command dispatcher: decodes the command FIFO head, starts the matching draw
// engine, waits for its completion (or watchdog abort) and pops the command.
module gpu_dispatcher
  import gpu_pkg::*;
#(
  parameter int X_BITS      = 10,
  parameter int Y_BITS      = 9,
  parameter int CH_BITS     = 8,
  parameter int NUM_ENG     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty_i,
  output logic               pop_o,
  input  logic [3:0]         opcode_i,
  input  logic [X_BITS-1:0]  x1_i,
  input  logic [Y_BITS-1:0]  y1_i,
  input  logic [X_BITS-1:0]  x2_i,
  input  logic [Y_BITS-1:0]  y2_i,
  input  logic [X_BITS-1:0]  rad_i,
  input  logic [2:0]         oct_i,
  input  logic [CH_BITS-1:0] r_i,
  input  logic [CH_BITS-1:0] g_i,
  input  logic [CH_BITS-1:0] b_i,
  input  logic [NUM_ENG-1:0] busy_i,
  input  logic [NUM_ENG-1:0] done_i,
  output logic [NUM_ENG-1:0] run_o,
  output logic [NUM_ENG-1:0] abort_o,
  output logic [X_BITS-1:0]  x1_o,
  output logic [Y_BITS-1:0]  y1_o,
  output logic [X_BITS-1:0]  x2_o,
  output logic [Y_BITS-1:0]  y2_o,
  output logic [X_BITS-1:0]  rad_o,
  output logic [2:0]         oct_o,
  output logic [CH_BITS-1:0] r_o,
  output logic [CH_BITS-1:0] g_o,
  output logic [CH_BITS-1:0] b_o,
  input  logic               clr_err_i,
  output logic               err_o,
  output logic [1:0]         err_code_o,
  output logic               idle_o
);

  localparam logic [NUM_ENG-1:0] ENG_ONE = {{(NUM_ENG-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [1:0]         eng_q, eng_d;
  logic [NUM_ENG-1:0] run_q, run_d;
  logic               pop_q, pop_d;
  logic               err_q, err_d;
  logic [1:0]         err_code_q, err_code_d;
  logic [NUM_ENG-1:0] abort_s;
  logic               latch_s, tmr_clr_s, tmr_en_s, tmr_exp_s, set_err_s;
  logic [1:0]         new_code_s;
  cmd_dec_t           dec_s;

  logic [X_BITS-1:0]  x1_q, x2_q, rad_q;
  logic [Y_BITS-1:0]  y1_q, y2_q;
  logic [2:0]         oct_q;
  logic [CH_BITS-1:0] r_q, g_q, b_q;

  assign dec_s = decode_op(opcode_i, NUM_ENG);

  dispatch_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (tmr_clr_s),
    .en_i     (tmr_en_s),
    .expire_o (tmr_exp_s)
  );

  // Next state and the pulses that are registered on entry to ISSUE / POP.
  always_comb begin
    state_d    = state_q;
    eng_d      = eng_q;
    run_d      = '0;
    pop_d      = 1'b0;
    abort_s    = '0;
    latch_s    = 1'b0;
    tmr_clr_s  = 1'b0;
    tmr_en_s   = 1'b0;
    set_err_s  = 1'b0;
    new_code_s = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_empty_i) begin
          state_d = ST_IDLE;
        end else if (dec_s.kind == CMD_ENG) begin
          if (!busy_i[dec_s.eng]) begin
            state_d = ST_ISSUE;
            eng_d   = dec_s.eng;
            latch_s = 1'b1;
            run_d   = ENG_ONE << dec_s.eng;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_POP;
          pop_d   = 1'b1;
          if (dec_s.kind == CMD_ILL) begin
            set_err_s  = 1'b1;
            new_code_s = ERR_ILLEGAL;
          end else begin
            set_err_s  = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        tmr_clr_s = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is checked before expiry so a coincident done wins.
        if (done_i[eng_q]) begin
          state_d = ST_POP;
          pop_d   = 1'b1;
        end else if (tmr_exp_s) begin
          state_d    = ST_POP;
          pop_d      = 1'b1;
          abort_s    = ENG_ONE << eng_q;
          set_err_s  = 1'b1;
          new_code_s = ERR_TIMEOUT;
        end else begin
          tmr_en_s = 1'b1;
        end
      end
      ST_POP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (set_err_s) begin
      err_d = 1'b1;
    end else if (clr_err_i) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
    err_code_d = new_code_s;
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      eng_q      <= 2'd0;
      run_q      <= '0;
      pop_q      <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      eng_q      <= eng_d;
      run_q      <= run_d;
      pop_q      <= pop_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Shared operand bus; arcs are centred on the head's second point.
  always_ff @(posedge clk) begin
    if (rst) begin
      x1_q <= '0; y1_q <= '0; x2_q <= '0; y2_q <= '0; rad_q <= '0;
      oct_q <= 3'd0; r_q <= '0; g_q <= '0; b_q <= '0;
    end else if (latch_s) begin
      x1_q  <= (opcode_i == OP_ARC) ? x2_i : x1_i;
      y1_q  <= (opcode_i == OP_ARC) ? y2_i : y1_i;
      x2_q  <= x2_i;
      y2_q  <= y2_i;
      rad_q <= rad_i;
      oct_q <= oct_i;
      r_q   <= r_i;
      g_q   <= g_i;
      b_q   <= b_i;
    end else begin
      x1_q <= x1_q; y1_q <= y1_q; x2_q <= x2_q; y2_q <= y2_q; rad_q <= rad_q;
      oct_q <= oct_q; r_q <= r_q; g_q <= g_q; b_q <= b_q;
    end
  end

  // Abort must see done_i in the expiry cycle itself, so it is not registered.
  assign abort_o    = rst ? '0 : abort_s;
  assign run_o      = run_q;
  assign pop_o      = pop_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign idle_o     = (state_q == ST_IDLE);
  assign x1_o  = x1_q;
  assign y1_o  = y1_q;
  assign x2_o  = x2_q;
  assign y2_o  = y2_q;
  assign rad_o = rad_q;
  assign oct_o = oct_q;
  assign r_o   = r_q;
  assign g_o   = g_q;
  assign b_o   = b_q;

endmodule

// File: tb/tb_gpu_dispatcher.sv
// Directed bench for gpu_dispatcher with a cycle-level command model and a
// small FIFO emulation driving the head fields.
module tb_gpu_dispatcher;

  localparam int XB = 10;
  localparam int YB = 9;
  localparam int CB = 8;
  localparam int NE = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          fifo_empty_i = 1'b1;
  logic          pop_o;
  logic [3:0]    opcode_i = 4'h0;
  logic [XB-1:0] x1_i = '0, x2_i = '0, rad_i = '0;
  logic [YB-1:0] y1_i = '0, y2_i = '0;
  logic [2:0]    oct_i = 3'd0;
  logic [CB-1:0] r_i = '0, g_i = '0, b_i = '0;
  logic [NE-1:0] busy_i = '0, done_i = '0;
  logic [NE-1:0] run_o, abort_o;
  logic [XB-1:0] x1_o, x2_o, rad_o;
  logic [YB-1:0] y1_o, y2_o;
  logic [2:0]    oct_o;
  logic [CB-1:0] r_o, g_o, b_o;
  logic          clr_err_i = 1'b0;
  logic          err_o;
  logic [1:0]    err_code_o;
  logic          idle_o;

  always #5 clk = ~clk;

  gpu_dispatcher #(
    .X_BITS(XB), .Y_BITS(YB), .CH_BITS(CB), .NUM_ENG(NE), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .fifo_empty_i(fifo_empty_i), .pop_o(pop_o),
    .opcode_i(opcode_i), .x1_i(x1_i), .y1_i(y1_i), .x2_i(x2_i), .y2_i(y2_i),
    .rad_i(rad_i), .oct_i(oct_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
    .busy_i(busy_i), .done_i(done_i), .run_o(run_o), .abort_o(abort_o),
    .x1_o(x1_o), .y1_o(y1_o), .x2_o(x2_o), .y2_o(y2_o), .rad_o(rad_o),
    .oct_o(oct_o), .r_o(r_o), .g_o(g_o), .b_o(b_o),
    .clr_err_i(clr_err_i), .err_o(err_o), .err_code_o(err_code_o), .idle_o(idle_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- FIFO emulation ----------------
  typedef struct {
    logic [3:0]    op;
    logic [XB-1:0] x1, x2, rad;
    logic [YB-1:0] y1, y2;
    logic [2:0]    oct;
    logic [CB-1:0] r, g, b;
  } cmd_t;
  cmd_t q[$];

  task automatic drive_head();
    if (q.size() == 0) begin
      fifo_empty_i = 1'b1;
      opcode_i     = 4'h0;
    end else begin
      fifo_empty_i = 1'b0;
      opcode_i = q[0].op;  x1_i = q[0].x1; y1_i = q[0].y1; x2_i = q[0].x2;
      y2_i = q[0].y2; rad_i = q[0].rad; oct_i = q[0].oct;
      r_i = q[0].r; g_i = q[0].g; b_i = q[0].b;
    end
  endtask

  task automatic push(input logic [3:0] op, input logic [XB-1:0] x1, input logic [YB-1:0] y1,
                      input logic [XB-1:0] x2, input logic [YB-1:0] y2, input logic [XB-1:0] rad,
                      input logic [2:0] oct, input logic [CB-1:0] r, input logic [CB-1:0] g,
                      input logic [CB-1:0] b);
    cmd_t c;
    c.op = op; c.x1 = x1; c.y1 = y1; c.x2 = x2; c.y2 = y2; c.rad = rad; c.oct = oct;
    c.r = r; c.g = g; c.b = b;
    q.push_back(c);
    drive_head();
  endtask

  // Advance one cycle; the FIFO head moves on after a cycle showing pop_o.
  task automatic tick();
    logic was_pop;
    @(negedge clk);
    was_pop = pop_o;
    @(posedge clk);
    #1;
    if (was_pop && q.size() > 0) void'(q.pop_front());
    drive_head();
  endtask

  // ---------------- behavioural model ----------------
  // Class of an opcode: -1 NOP, -2 illegal, otherwise the engine index.
  function automatic int op_class(input logic [3:0] op);
    case (op)
      4'b0000: return -1;
      4'b0100: return 0;
      4'b0101: return 1;
      4'b0111: return 2;
      4'b0110: return (NE > 3) ? 3 : -2;
      default: return -2;
    endcase
  endfunction

  // m_age counts cycles since run_o (0 = the run_o cycle itself).
  bit            m_valid = 0, m_inflight = 0, m_pop = 0, m_err = 0;
  int            m_age = 0, m_eng = 0;
  logic [NE-1:0] m_run = '0;
  logic [1:0]    m_code = 2'b00;
  logic [XB-1:0] m_x1 = '0, m_x2 = '0, m_rad = '0;
  logic [YB-1:0] m_y1 = '0, m_y2 = '0;
  logic [2:0]    m_oct = 3'd0;
  logic [CB-1:0] m_r = '0, m_g = '0, m_b = '0;

  always @(posedge clk) begin
    int         cls, age;
    bit         inflight, pop_n, seterr, latch;
    logic [1:0] code_n;
    logic [NE-1:0] run_n;
    inflight = m_inflight; age = m_age; pop_n = 0; seterr = 0; latch = 0;
    code_n = m_code; run_n = '0; cls = 0;
    if (rst) begin
      m_valid <= 1; m_inflight <= 0; m_age <= 0; m_pop <= 0; m_run <= '0;
      m_err <= 0; m_code <= 2'b00; m_eng <= 0;
      m_x1 <= '0; m_y1 <= '0; m_x2 <= '0; m_y2 <= '0; m_rad <= '0;
      m_oct <= 3'd0; m_r <= '0; m_g <= '0; m_b <= '0;
    end else if (m_valid) begin
      if (!m_pop) begin
        if (m_inflight) begin
          if (age == 0) age = 1;
          else if (done_i[m_eng]) begin inflight = 0; pop_n = 1; end
          else if (age == TO) begin inflight = 0; pop_n = 1; seterr = 1; code_n = 2'b10; end
          else age = age + 1;
        end else if (!fifo_empty_i) begin
          cls = op_class(opcode_i);
          if (cls == -1) pop_n = 1;
          else if (cls == -2) begin pop_n = 1; seterr = 1; code_n = 2'b01; end
          else if (!busy_i[cls]) begin
            inflight = 1; age = 0; latch = 1;
            run_n = NE'(1) << cls;
          end
        end
      end
      m_inflight <= inflight; m_age <= age; m_pop <= pop_n; m_run <= run_n;
      m_code <= code_n;
      if (seterr) m_err <= 1;
      else if (clr_err_i) m_err <= 0;
      if (latch) begin
        m_eng <= cls;
        m_x1 <= (opcode_i == 4'b0111) ? x2_i : x1_i;
        m_y1 <= (opcode_i == 4'b0111) ? y2_i : y1_i;
        m_x2 <= x2_i; m_y2 <= y2_i; m_rad <= rad_i; m_oct <= oct_i;
        m_r <= r_i; m_g <= g_i; m_b <= b_i;
      end
    end
  end

  // Compare every DUT output against the model once per cycle.
  always @(negedge clk) begin
    logic [NE-1:0] exp_abort;
    int n_act;
    if (m_valid) begin
      exp_abort = (m_inflight && m_age == TO && !done_i[m_eng] && !rst) ? NE'(1) << m_eng : '0;
      check("m run_o",      32'(run_o),      32'(m_run));
      check("m pop_o",      32'(pop_o),      32'(m_pop));
      check("m abort_o",    32'(abort_o),    32'(exp_abort));
      check("m idle_o",     32'(idle_o),     32'(!m_inflight && !m_pop));
      check("m err_o",      32'(err_o),      32'(m_err));
      check("m err_code_o", 32'(err_code_o), 32'(m_code));
      check("m x1_o", 32'(x1_o), 32'(m_x1));
      check("m y1_o", 32'(y1_o), 32'(m_y1));
      check("m x2_o", 32'(x2_o), 32'(m_x2));
      check("m y2_o", 32'(y2_o), 32'(m_y2));
      check("m rad_o", 32'(rad_o), 32'(m_rad));
      check("m oct_o", 32'(oct_o), 32'(m_oct));
      check("m rgb_o", 32'({r_o, g_o, b_o}), 32'({m_r, m_g, m_b}));
      n_act = int'(|run_o) + int'(|abort_o) + int'(pop_o);
      check("m exclusive pulses", 32'(n_act > 1), 32'd0);
      if (pop_o) pop_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int pc0;
    drive_head();
    tick(); tick();
    check("rst idle_o", 32'(idle_o), 32'd1);
    check("rst run_o", 32'(run_o), 32'd0);
    check("rst pop_o", 32'(pop_o), 32'd0);
    check("rst err_o", 32'(err_o), 32'd0);
    check("rst x1_o", 32'(x1_o), 32'd0);
    rst = 1'b0;
    tick();

    // Line to engine 0.
    pc0 = pop_cnt;
    push(4'b0100, 10'd10, 9'd20, 10'd300, 9'd200, 10'd0, 3'd0, 8'd1, 8'd2, 8'd3);
    tick();
    check("line run_o", 32'(run_o), 32'h1);
    check("line x1_o", 32'(x1_o), 32'd10);
    check("line y1_o", 32'(y1_o), 32'd20);
    check("line x2_o", 32'(x2_o), 32'd300);
    check("line y2_o", 32'(y2_o), 32'd200);
    tick();
    check("line run once", 32'(run_o), 32'h0);
    tick(); tick();
    check("line x1 stable", 32'(x1_o), 32'd10);
    check("line y2 stable", 32'(y2_o), 32'd200);
    done_i = 4'b0001;
    tick();
    done_i = 4'b0000;
    check("line pop_o", 32'(pop_o), 32'd1);
    tick(); tick();
    check("line one pop", 32'(pop_cnt - pc0), 32'd1);
    check("line idle", 32'(idle_o), 32'd1);
    check("line x2 hold", 32'(x2_o), 32'd300);

    // Arc to engine 2.
    push(4'b0111, 10'd7, 9'd8, 10'd50, 9'd60, 10'd25, 3'd3, 8'd9, 8'd9, 8'd9);
    tick();
    check("arc run_o", 32'(run_o), 32'h4);
    check("arc x1_o", 32'(x1_o), 32'd50);
    check("arc y1_o", 32'(y1_o), 32'd60);
    check("arc rad_o", 32'(rad_o), 32'd25);
    check("arc oct_o", 32'(oct_o), 32'd3);
    tick(); tick();
    done_i = 4'b0100;
    tick();
    done_i = 4'b0000;
    check("arc pop_o", 32'(pop_o), 32'd1);
    tick();

    // Fill held off by a busy engine 1 for five cycles.
    busy_i = 4'b0010;
    push(4'b0101, 10'd100, 9'd101, 10'd102, 9'd103, 10'd0, 3'd1, 8'd4, 8'd5, 8'd6);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fill no run while busy", 32'(run_o), 32'h0);
    end
    busy_i = 4'b0000;
    tick();
    check("fill run_o", 32'(run_o), 32'h2);
    done_i = 4'b0010;
    tick();
    done_i = 4'b0001;
    check("fill done in issue ignored", 32'(pop_o), 32'd0);
    tick();
    check("fill other done ignored", 32'(pop_o), 32'd0);
    check("fill still busy", 32'(idle_o), 32'd0);
    done_i = 4'b0010;
    tick();
    done_i = 4'b0000;
    check("fill pop_o", 32'(pop_o), 32'd1);
    tick();

    // Watchdog expiry on engine 0.
    push(4'b0100, 10'd1, 9'd2, 10'd3, 9'd4, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("to run_o", 32'(run_o), 32'h1);
    for (int j = 1; j < 8; j++) begin
      tick();
      check("to no early abort", 32'(abort_o), 32'h0);
    end
    tick();
    check("to abort_o", 32'(abort_o), 32'h1);
    check("to no pop with abort", 32'(pop_o), 32'd0);
    tick();
    check("to pop_o", 32'(pop_o), 32'd1);
    check("to abort once", 32'(abort_o), 32'h0);
    check("to err_o", 32'(err_o), 32'd1);
    check("to err_code_o", 32'(err_code_o), 32'h2);
    tick();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("to err cleared", 32'(err_o), 32'd0);
    check("to code held", 32'(err_code_o), 32'h2);

    // Done coinciding with expiry: done wins.
    push(4'b0101, 10'd1, 9'd1, 10'd1, 9'd1, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("tie run_o", 32'(run_o), 32'h2);
    for (int j = 1; j < 8; j++) tick();
    tick();
    done_i = 4'b0010;
    #1;
    check("tie no abort", 32'(abort_o), 32'h0);
    tick();
    done_i = 4'b0000;
    check("tie pop_o", 32'(pop_o), 32'd1);
    check("tie no err", 32'(err_o), 32'd0);
    tick();

    // Illegal opcode followed by a NOP.
    pc0 = pop_cnt;
    push(4'b1111, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    push(4'b0000, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("ill pop_o", 32'(pop_o), 32'd1);
    check("ill no run", 32'(run_o), 32'h0);
    tick();
    check("ill err_o", 32'(err_o), 32'd1);
    check("ill err_code_o", 32'(err_code_o), 32'h1);
    check("ill single pop", 32'(pop_o), 32'd0);
    tick();
    check("nop pop_o", 32'(pop_o), 32'd1);
    tick(); tick();
    check("ill+nop two pops", 32'(pop_cnt - pc0), 32'd2);
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    check("ill err cleared", 32'(err_o), 32'd0);
    check("ill code held", 32'(err_code_o), 32'h1);

    // New error in the same cycle as a clear: the error wins.
    clr_err_i = 1'b1;
    push(4'b1001, 10'd0, 9'd0, 10'd0, 9'd0, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    clr_err_i = 1'b0;
    check("err beats clr", 32'(err_o), 32'd1);
    tick(); tick();
    check("err sticky", 32'(err_o), 32'd1);

    // Engine 3 opcode.
    push(4'b0110, 10'd33, 9'd34, 10'd35, 9'd36, 10'd0, 3'd0, 8'd0, 8'd0, 8'd0);
    tick();
    check("eng3 run_o", 32'(run_o), 32'h8);
    tick();
    done_i = 4'b1000;
    tick();
    done_i = 4'b0000;
    check("eng3 pop_o", 32'(pop_o), 32'd1);
    tick();

    // Reset while waiting on an engine.
    pc0 = pop_cnt;
    push(4'b0100, 10'd11, 9'd12, 10'd13, 9'd14, 10'd15, 3'd5, 8'd16, 8'd17, 8'd18);
    tick(); tick(); tick();
    check("rstw in wait", 32'(idle_o), 32'd0);
    rst = 1'b1;
    q.delete();
    drive_head();
    tick();
    check("rstw run_o", 32'(run_o), 32'h0);
    check("rstw pop_o", 32'(pop_o), 32'd0);
    check("rstw abort_o", 32'(abort_o), 32'h0);
    check("rstw err_o", 32'(err_o), 32'd0);
    check("rstw err_code_o", 32'(err_code_o), 32'h0);
    check("rstw x1_o", 32'(x1_o), 32'd0);
    check("rstw rad_o", 32'(rad_o), 32'd0);
    check("rstw idle_o", 32'(idle_o), 32'd1);
    rst = 1'b0;
    tick(); tick();
    check("rstw no pop", 32'(pop_cnt - pc0), 32'd0);
    push(4'b0101, 10'd5, 9'd6, 10'd7, 9'd8, 10'd9, 3'd2, 8'd1, 8'd1, 8'd1);
    tick();
    check("rstw fresh run_o", 32'(run_o), 32'h2);
    check("rstw fresh x1_o", 32'(x1_o), 32'd5);
    tick();
    done_i = 4'b0010;
    tick();
    done_i = 4'b0000;
    check("rstw fresh pop_o", 32'(pop_o), 32'd1);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
